// File: rtl/phy_tx_word_sched.sv
// Transmit word scheduler for the serial PHY. It runs comma training and link bring-up,
// then merges two lanes round-robin onto a single registered word stream.
module phy_tx_word_sched #(
  parameter int unsigned TRAIN_WORDS  = 4,
  parameter int unsigned LINK_TIMEOUT = 64
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_in0,
  input  logic       valid_in0,
  output logic       ready_out0,
  input  logic [7:0] data_in1,
  input  logic       valid_in1,
  output logic       ready_out1,
  input  logic       rx_active,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active_out,
  output logic [1:0] state_out,
  output logic       bc_collision
);

  localparam logic [7:0] COMMA      = 8'hBC;
  localparam logic [3:0] TRAIN_LAST = 4'(TRAIN_WORDS - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(LINK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RESET     = 2'b00,
    ST_TRAIN     = 2'b01,
    ST_WAIT_LINK = 2'b10,
    ST_ACTIVE    = 2'b11
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] train_cnt;
  logic [7:0] wait_cnt;
  logic       rr_ptr;
  logic       grant_any;
  logic       grant_lane;
  logic [7:0] grant_word;

  always_comb begin
    state_nxt  = state;
    grant_any  = 1'b0;
    grant_lane = 1'b0;
    case (state)
      ST_RESET:     state_nxt = ST_TRAIN;
      ST_TRAIN:     if (train_cnt == TRAIN_LAST) state_nxt = ST_WAIT_LINK;
      ST_WAIT_LINK: begin
        if (rx_active)                  state_nxt = ST_ACTIVE;
        else if (wait_cnt == WAIT_LAST) state_nxt = ST_TRAIN;
      end
      ST_ACTIVE:    if (!rx_active) state_nxt = ST_TRAIN;
      default:      state_nxt = ST_RESET;
    endcase
    // Grants only while the link is up; reset masks the pops so nothing is lost mid-reset.
    if (state == ST_ACTIVE && rx_active && !reset) begin
      if (valid_in0 && valid_in1) begin
        grant_any  = 1'b1;
        grant_lane = rr_ptr;
      end else if (valid_in0) begin
        grant_any  = 1'b1;
        grant_lane = 1'b0;
      end else if (valid_in1) begin
        grant_any  = 1'b1;
        grant_lane = 1'b1;
      end
    end
  end

  assign grant_word = grant_lane ? data_in1 : data_in0;
  assign ready_out0 = grant_any && !grant_lane;
  assign ready_out1 = grant_any && grant_lane;
  assign state_out  = state;

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state        <= ST_RESET;
      data_out     <= COMMA;
      valid_out    <= 1'b0;
      active_out   <= 1'b0;
      bc_collision <= 1'b0;
      rr_ptr       <= 1'b0;
      train_cnt    <= '0;
      wait_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      active_out <= (state_nxt == ST_ACTIVE);
      if (state_nxt != state) begin
        train_cnt <= '0;
        wait_cnt  <= '0;
      end else begin
        if (state == ST_TRAIN)     train_cnt <= train_cnt + 4'd1;
        if (state == ST_WAIT_LINK) wait_cnt  <= wait_cnt + 8'd1;
      end
      // A lane word that looks like a comma is swallowed and replaced by idle fill.
      if (grant_any && grant_word != COMMA) begin
        data_out  <= grant_word;
        valid_out <= 1'b1;
      end else begin
        data_out  <= COMMA;
        valid_out <= 1'b0;
      end
      if (grant_any) rr_ptr <= ~grant_lane;
      if (grant_any && grant_word == COMMA) bc_collision <= 1'b1;
    end
  end

endmodule
